fifo_gray_ptr_ctrl: RTL and testbench
=====================================

# fifo_gray_ptr_ctrl

Parametrised pointer and flag controller for one side of the asynchronous dual-clock FIFO, instantiated once per clock domain. It keeps an (ADDR_WIDTH+1)-bit binary and Gray pointer, synchronises the opposite domain's Gray pointer through a configurable flop chain, and derives full or empty, almost-full or almost-empty, and occupancy. The extra MSB disambiguates full from empty. Gray reset value is zero.

## Interface
- ADDR_WIDTH, 3: memory address bits; DEPTH = 2**ADDR_WIDTH; legal range 2..12.
- SYNC_STAGES, 2: remote-pointer synchroniser depth; legal range 2..4.
- IS_WRITE, 1: 1 = write side (full/almost-full); 0 = read side (empty/almost-empty).
- ALMOST_THRESH, 2: almost-flag margin in words; legal range 1..DEPTH-1.

- clk  in  1  local domain clock
- reset  in  1  synchronous, active-low
- inc  in  1  push (write side) or pop (read side) request
- remote_gray  in  ADDR_WIDTH+1  opposite domain's gray_ptr, asynchronous to clk
- accepted  out  1  combinational: inc & ~flag
- bin_addr  out  ADDR_WIDTH  registered memory address (binary pointer LSBs)
- gray_ptr  out  ADDR_WIDTH+1  registered Gray pointer, sent to opposite domain
- flag  out  1  full (IS_WRITE=1) or empty (IS_WRITE=0), registered
- almost_flag  out  1  almost-full or almost-empty, registered
- level  out  ADDR_WIDTH+1  occupancy 0..DEPTH as seen from this domain, registered

## Operation
- Reset (reset=0 at posedge): bin, gray_ptr, bin_addr, every sync stage, level = 0; flag = 0 on write side, 1 on read side; almost_flag = 0 on write side, 1 on read side. inc ignored during reset.
- Increment gated: bin_next = bin + accepted, modulo 2**(ADDR_WIDTH+1); gray_next = bin_next ^ (bin_next >> 1). inc while flag=1 is dropped: no pointer change.
- gray_ptr is a direct flop of gray_next; no combinational logic after the flop. Successive values differ in exactly one bit, including wrap 2*DEPTH-1 -> 0.
- Synchroniser: remote_gray -> SYNC_STAGES flops; last stage = rsync. rbin = Gray-to-binary of rsync (prefix XOR from MSB).
- Write side: occupancy = (bin_next - rbin) mod 2**(ADDR_WIDTH+1); full_next = (gray_next == {~rsync[MSB:MSB-1], rsync[MSB-2:0]}); almost_next = occupancy >= DEPTH - ALMOST_THRESH.
- Read side: occupancy = (rbin - bin_next) mod 2**(ADDR_WIDTH+1); empty_next = (gray_next == rsync); almost_next = occupancy <= ALMOST_THRESH.
- flag, almost_flag, level register the *_next values at the same edge as the pointer update.
- Flags conservative: remote pointer lag only delays deassertion of full/empty, never deasserts early. Remote pointer assumed to change at most one Gray step per local cycle or to be sampled stable.

## Timing
- Local inc: accepted combinational in same cycle; pointer, flag, level update at that clock edge (0 extra cycles).
- Remote change: stable at remote_gray before edge t -> in rsync after SYNC_STAGES edges -> flag/level reflect it at edge t+SYNC_STAGES.
- Simultaneous local accept and rsync change in the same cycle: both folded into one *_next evaluation; no lost update.
- Reset mid-operation: all state returns to reset values at the next edge regardless of inc; sync chain cleared; partner side must also be reset.

## Test plan
- Write side, ADDR_WIDTH=3, remote_gray=0, inc held 9 cycles -> gray_ptr 1,3,2,6,7,5,4,C; flag=1 at edge 8, level=8; 9th cycle accepted=0, gray_ptr stays C.
- Same setup -> almost_flag rises at edge 6 (level 6 = 8-2); falls after remote_gray set to 4 (bin 7): full drops, level 1 exactly SYNC_STAGES edges later.
- Read side, reset -> flag=1, level 0; remote_gray 0 -> 1 -> flag=0, level 1 after 2 edges (SYNC_STAGES=2), SYNC_STAGES=4 -> after 4 edges.
- Wrap: 16 accepted incs with remote tracking -> gray_ptr returns to 0, exactly one bit toggles per step, bin_addr cycles 0..7 twice.
- Simultaneous: read side level 1, inc plus remote step on same cycle -> level stays 1, flag stays 0.
- Reset asserted at level 5 with inc=1 -> next edge all outputs at reset values, accepted ignored.

Source files
------------

// File: rtl/fifo_gray_ptr_ctrl_if.sv
// ---------------------------------------------------------------------------
// fifo_gray_ptr_ctrl_if
// Groups the per-side signals of one dual-clock FIFO pointer controller.
//   inc          push (write side) or pop (read side) request
//   remote_gray  opposite domain's Gray pointer, asynchronous to clk
//   accepted     request taken this cycle (inc and not full/empty)
//   bin_addr     binary memory address for this side
//   gray_ptr     registered Gray pointer, sent to the opposite domain
//   flag         full (write side) or empty (read side)
//   almost_flag  almost-full or almost-empty
//   level        occupancy 0..DEPTH as seen from this domain
// master: whoever drives requests and the remote pointer.
// slave:  the pointer controller itself.
// ---------------------------------------------------------------------------
interface fifo_gray_ptr_ctrl_if #(
  parameter int ADDR_WIDTH = 3
);
  logic                  inc;
  logic [ADDR_WIDTH:0]   remote_gray;
  logic                  accepted;
  logic [ADDR_WIDTH-1:0] bin_addr;
  logic [ADDR_WIDTH:0]   gray_ptr;
  logic                  flag;
  logic                  almost_flag;
  logic [ADDR_WIDTH:0]   level;

  modport master (
    output inc, remote_gray,
    input  accepted, bin_addr, gray_ptr, flag, almost_flag, level
  );

  modport slave (
    input  inc, remote_gray,
    output accepted, bin_addr, gray_ptr, flag, almost_flag, level
  );
endinterface

// File: rtl/fifo_gray_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_gray_ptr_ctrl
// Pointer and flag controller for one side of an asynchronous dual-clock
// FIFO; one instance per clock domain. Keeps an (ADDR_WIDTH+1)-bit binary and
// Gray pointer, synchronises the opposite domain's Gray pointer through a
// SYNC_STAGES flop chain and derives full/empty, almost-full/almost-empty and
// occupancy. The extra pointer MSB tells full apart from empty.
// Ports:
//   clk    local domain clock
//   reset  synchronous, active-low
//   bus    fifo_gray_ptr_ctrl_if.slave (inc, remote_gray in; accepted,
//          bin_addr, gray_ptr, flag, almost_flag, level out)
// Parameters:
//   ADDR_WIDTH    memory address bits (2..12), DEPTH = 2**ADDR_WIDTH
//   SYNC_STAGES   remote pointer synchroniser depth (2..4)
//   IS_WRITE      1 = write side (full), 0 = read side (empty)
//   ALMOST_THRESH almost-flag margin in words (1..DEPTH-1)
// ---------------------------------------------------------------------------
module fifo_gray_ptr_ctrl #(
  parameter int ADDR_WIDTH    = 3,
  parameter int SYNC_STAGES   = 2,
  parameter bit IS_WRITE      = 1'b1,
  parameter int ALMOST_THRESH = 2
) (
  input logic                 clk,
  input logic                 reset,
  fifo_gray_ptr_ctrl_if.slave bus
);
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] ALMOST_FULL_MARK  = PW'(DEPTH - ALMOST_THRESH);
  localparam logic [PW-1:0] ALMOST_EMPTY_MARK = PW'(ALMOST_THRESH);

  logic [PW-1:0] bin_q;
  logic [PW-1:0] gray_q;
  logic [PW-1:0] level_q;
  logic          flag_q;
  logic          almost_q;
  logic [PW-1:0] sync_q [SYNC_STAGES];

  logic [PW-1:0] rsync;
  logic [PW-1:0] rbin;
  logic [PW-1:0] bin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] occ_next;
  logic          flag_next;
  logic          almost_next;

  // A request while full/empty is dropped; the pointer does not move.
  assign bus.accepted = bus.inc & ~flag_q;
  assign bin_next     = bin_q + PW'(bus.accepted);
  assign gray_next    = bin_next ^ (bin_next >> 1);
  assign rsync        = sync_q[SYNC_STAGES-1];

  // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch or
    // loop, so no path leaves it unassigned and no latch is inferred.
    rbin = '0;
    for (int i = 0; i < PW; i++) begin
      rbin[i] = ^(rsync >> i);
    end
  end

  // Flags use the local pointer after this cycle's accept and the remote
  // pointer as synchronised, so a local accept and a remote step landing in
  // the same cycle are folded into one evaluation. The remote pointer can
  // only lag, which delays deassertion of full/empty but never hastens it.
  always_comb begin
    occ_next    = '0;
    flag_next   = 1'b0;
    almost_next = 1'b0;
    if (IS_WRITE) begin
      occ_next    = bin_next - rbin;
      // Full: same address bits, opposite wrap bit. In Gray code that is the
      // top two bits inverted and the rest equal.
      flag_next   = (gray_next == {~rsync[PW-1:PW-2], rsync[PW-3:0]});
      almost_next = (occ_next >= ALMOST_FULL_MARK);
    end else begin
      occ_next    = rbin - bin_next;
      flag_next   = (gray_next == rsync);
      almost_next = (occ_next <= ALMOST_EMPTY_MARK);
    end
  end

  // Remote pointer synchroniser. The chain is cleared by reset so a stale
  // pointer from before reset cannot reach the flags afterwards.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: a multi-entry register array is reset stage by stage in a loop;
      // this chain is only SYNC_STAGES words, so clearing it is cheap.
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= bus.remote_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Pointer and flag state. The Gray pointer is a direct flop so the
  // opposite domain never samples a combinational glitch.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    if (!reset) begin
      bin_q    <= '0;
      gray_q   <= '0;
      level_q  <= '0;
      flag_q   <= !IS_WRITE;
      almost_q <= !IS_WRITE;
    end else begin
      bin_q    <= bin_next;
      gray_q   <= gray_next;
      level_q  <= occ_next;
      flag_q   <= flag_next;
      almost_q <= almost_next;
    end
  end

  assign bus.bin_addr    = bin_q[ADDR_WIDTH-1:0];
  assign bus.gray_ptr    = gray_q;
  assign bus.flag        = flag_q;
  assign bus.almost_flag = almost_q;
  assign bus.level       = level_q;
endmodule

// File: tb/tb_fifo_gray_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_gray_ptr_ctrl
// Three controllers run side by side: write side with 2 sync stages, read
// side with 2 and read side with 4. A driver issues random requests and a
// random but legal partner pointer, keeps a count-based model of each FIFO
// side, and queues the expected outputs; a monitor compares them against the
// DUTs on the falling edge. Directed stretches cover fill-to-full, wrap,
// and a reset taken mid-operation with requests active.
// ---------------------------------------------------------------------------
module tb_fifo_gray_ptr_ctrl;
  localparam int AW  = 3;
  localparam int D   = 1 << AW;
  localparam int M   = 2 * D;
  localparam int TH  = 2;
  localparam int N   = 3;
  localparam int CYC = 700;

  typedef struct {
    int         dut;
    logic       acc;
    logic [AW:0] gray;
    logic [AW-1:0] addr;
    logic       flag;
    logic       almost;
    logic [AW:0] level;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          inc_v [N];
  logic [AW:0]   rg_v  [N];
  logic          acc_o [N];
  logic [AW-1:0] addr_o[N];
  logic [AW:0]   gray_o[N];
  logic          flag_o[N];
  logic          alm_o [N];
  logic [AW:0]   lvl_o [N];

  fifo_gray_ptr_ctrl_if #(.ADDR_WIDTH(AW)) bus_w2 ();
  fifo_gray_ptr_ctrl_if #(.ADDR_WIDTH(AW)) bus_r2 ();
  fifo_gray_ptr_ctrl_if #(.ADDR_WIDTH(AW)) bus_r4 ();

  fifo_gray_ptr_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(2), .IS_WRITE(1'b1), .ALMOST_THRESH(TH))
    u_w2 (.clk(clk), .reset(reset), .bus(bus_w2.slave));
  fifo_gray_ptr_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(2), .IS_WRITE(1'b0), .ALMOST_THRESH(TH))
    u_r2 (.clk(clk), .reset(reset), .bus(bus_r2.slave));
  fifo_gray_ptr_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(4), .IS_WRITE(1'b0), .ALMOST_THRESH(TH))
    u_r4 (.clk(clk), .reset(reset), .bus(bus_r4.slave));

  assign bus_w2.inc = inc_v[0];  assign bus_w2.remote_gray = rg_v[0];
  assign bus_r2.inc = inc_v[1];  assign bus_r2.remote_gray = rg_v[1];
  assign bus_r4.inc = inc_v[2];  assign bus_r4.remote_gray = rg_v[2];

  assign acc_o[0] = bus_w2.accepted; assign addr_o[0] = bus_w2.bin_addr;
  assign gray_o[0] = bus_w2.gray_ptr; assign flag_o[0] = bus_w2.flag;
  assign alm_o[0] = bus_w2.almost_flag; assign lvl_o[0] = bus_w2.level;
  assign acc_o[1] = bus_r2.accepted; assign addr_o[1] = bus_r2.bin_addr;
  assign gray_o[1] = bus_r2.gray_ptr; assign flag_o[1] = bus_r2.flag;
  assign alm_o[1] = bus_r2.almost_flag; assign lvl_o[1] = bus_r2.level;
  assign acc_o[2] = bus_r4.accepted; assign addr_o[2] = bus_r4.bin_addr;
  assign gray_o[2] = bus_r4.gray_ptr; assign flag_o[2] = bus_r4.flag;
  assign alm_o[2] = bus_r4.almost_flag; assign lvl_o[2] = bus_r4.level;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t sbq[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit is_wr(input int i);
    return (i == 0);
  endfunction

  function automatic int ss_of(input int i);
    return (i == 2) ? 4 : 2;
  endfunction

  function automatic int modm(input int v);
    return ((v % M) + M) % M;
  endfunction

  function automatic logic [AW:0] to_gray(input int b);
    logic [AW:0] v;
    v = (AW+1)'(b);
    return v ^ (v >> 1);
  endfunction

  // Behavioural model: each side is a pair of word counts (local, partner).
  int  lcnt [N];
  int  rcnt [N];
  int  rhist[N][5];   // rhist[i][k] = partner count presented k edges ago
  bit  mflag[N];
  bit  malm [N];
  int  mlvl [N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      lcnt[i] = 0;
      rcnt[i] = 0;
      for (int k = 0; k < 5; k++) rhist[i][k] = 0;
      mflag[i] = !is_wr(i);
      malm[i]  = !is_wr(i);
      mlvl[i]  = 0;
    end
  endtask

  // Advance side i across one active edge with request inc.
  task automatic model_step(input int i, input bit inc);
    int seen;
    int occ;
    for (int k = 4; k > 0; k--) rhist[i][k] = rhist[i][k-1];
    rhist[i][0] = rcnt[i];
    // Flags at this edge see the partner count from SYNC_STAGES edges back.
    seen = rhist[i][ss_of(i)];
    if (inc && !mflag[i]) lcnt[i] = modm(lcnt[i] + 1);
    if (is_wr(i)) begin
      occ      = modm(lcnt[i] - seen);
      mflag[i] = (occ == D);
      malm[i]  = (occ >= D - TH);
    end else begin
      occ      = modm(seen - lcnt[i]);
      mflag[i] = (occ == 0);
      malm[i]  = (occ <= TH);
    end
    mlvl[i] = occ;
  endtask

  // Monitor: compares whatever the driver queued against the DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        check($sformatf("d%0d accepted", e.dut), int'(acc_o[e.dut]), int'(e.acc));
        check($sformatf("d%0d gray_ptr", e.dut), int'(gray_o[e.dut]), int'(e.gray));
        check($sformatf("d%0d bin_addr", e.dut), int'(addr_o[e.dut]), int'(e.addr));
        check($sformatf("d%0d flag", e.dut), int'(flag_o[e.dut]), int'(e.flag));
        check($sformatf("d%0d almost_flag", e.dut), int'(alm_o[e.dut]), int'(e.almost));
        check($sformatf("d%0d level", e.dut), int'(lvl_o[e.dut]), int'(e.level));
      end
    end
  end

  // Driver and reference model.
  initial begin
    bit   rst_now;
    bit   inc;
    int   p_loc;
    int   p_rem;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      inc_v[i] = 1'b1;
      rg_v[i]  = '0;
    end
    model_reset();
    for (int c = 0; c < CYC; c++) begin
      @(posedge clk);
      #2;
      rst_now = (c < 2) || (c >= 400 && c < 402);
      reset   = !rst_now;
      for (int i = 0; i < N; i++) begin
        // Partner moves at most one step per cycle and never past what the
        // local side allows: a reader cannot pass the writer, a writer
        // cannot get more than DEPTH ahead.
        if (c >= 14 && !rst_now) begin
          p_loc = ((c / 64) % 2 == 1) ? 85 : 30;
          p_rem = ((c / 64) % 2 == 1) ? 30 : 85;
          if (!is_wr(i)) begin
            int t;
            t = p_loc; p_loc = p_rem; p_rem = t;
          end
          if ($urandom_range(99) < p_rem) begin
            if (is_wr(i) && modm(lcnt[i] - rcnt[i]) > 0) rcnt[i] = modm(rcnt[i] + 1);
            if (!is_wr(i) && modm(rcnt[i] - lcnt[i]) < D) rcnt[i] = modm(rcnt[i] + 1);
          end
          inc = ($urandom_range(99) < p_loc);
        end else begin
          // Reset and the opening fill: request every cycle, partner idle.
          inc = 1'b1;
        end
        inc_v[i] = inc;
        rg_v[i]  = to_gray(rcnt[i]);
        e.dut    = i;
        e.acc    = inc & !mflag[i];
        e.gray   = to_gray(lcnt[i]);
        e.addr   = AW'(lcnt[i] % D);
        e.flag   = mflag[i];
        e.almost = malm[i];
        e.level  = (AW+1)'(mlvl[i]);
        sbq.push_back(e);
      end
      if (rst_now) model_reset();
      else for (int i = 0; i < N; i++) model_step(i, inc_v[i]);
    end
    @(negedge clk);
    #1;
    check("scoreboard drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
